// File: rtl/cache_pkg.sv
// Shared types and constants for the 2-way write-through read cache.
// Holds the address split helper used by the controller.
package cache_pkg;
   localparam int          TAG_W     = 9;
   localparam int          IDX_W     = 6;
   localparam int          LINE_W    = 64;
   localparam int          SETS      = 64;
   localparam logic [31:0] BASE_ADDR = 32'd1024;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FILL0 = 2'd1,
      FILL1 = 2'd2,
      WRITE = 2'd3
   } cache_state_t;

   typedef struct packed {
      logic [TAG_W-1:0] tag;
      logic [IDX_W-1:0] idx;
      logic             word_sel;
   } addr_fields_t;

   // Offset is taken relative to the data-memory base before splitting.
   function automatic addr_fields_t split_addr(input logic [31:0] address);
      logic [17:0] offset;
      offset = address[17:0] - BASE_ADDR[17:0];
      split_addr.tag      = offset[17:9];
      split_addr.idx      = offset[8:3];
      split_addr.word_sel = offset[2];
   endfunction
endpackage

// File: rtl/cache_controller_if.sv
// MEM-stage request/response and SRAM-controller signals of the cache.
// slave = cache side; master = the MEM stage plus SRAM controller around it.
interface cache_controller_if;
   // Handshake: a request (rd_en or wr_en) is held until the cycle ready=1,
   // which completes it; an SRAM request is held until its 1-cycle sram_ready.
   logic        rd_en;
   logic        wr_en;
   logic [31:0] address;
   logic [31:0] write_data;
   logic [31:0] read_data;
   logic        ready;
   logic        sram_rd_en;
   logic        sram_wr_en;
   logic [31:0] sram_address;
   logic [31:0] sram_wdata;
   logic [31:0] sram_rdata;
   logic        sram_ready;

   modport slave (
      input  rd_en, wr_en, address, write_data, sram_rdata, sram_ready,
      output read_data, ready, sram_rd_en, sram_wr_en, sram_address, sram_wdata
   );

   modport master (
      output rd_en, wr_en, address, write_data, sram_rdata, sram_ready,
      input  read_data, ready, sram_rd_en, sram_wr_en, sram_address, sram_wdata
   );
endinterface

// File: rtl/cache_way.sv
// One way of the cache: valid/tag/data arrays, combinational hit,
// a full-line write port for fills and a single-word write port for stores.
module cache_way
   import cache_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic [IDX_W-1:0]  idx,
   input  logic [TAG_W-1:0]  tag,
   output logic              valid,
   output logic              hit,
   output logic [LINE_W-1:0] line,
   input  logic              line_we,
   input  logic [LINE_W-1:0] line_wdata,
   input  logic              word_we,
   input  logic              word_sel,
   input  logic [31:0]       word_wdata
);
   logic [SETS-1:0]   valid_q;
   logic [TAG_W-1:0]  tag_q  [SETS];
   logic [LINE_W-1:0] data_q [SETS];

   always_ff @(posedge clk) begin
      if (rst) valid_q <= '0;
      else if (line_we) valid_q[idx] <= 1'b1;
   end

   // Arrays carry no reset; a write during reset is suppressed so no stale line survives.
   always_ff @(posedge clk) begin
      if (!rst && line_we) begin
         tag_q[idx]  <= tag;
         data_q[idx] <= line_wdata;
      end else if (!rst && word_we) begin
         if (word_sel) data_q[idx][63:32] <= word_wdata;
         else          data_q[idx][31:0]  <= word_wdata;
      end
   end

   assign valid = valid_q[idx];
   assign hit   = valid_q[idx] && (tag_q[idx] == tag);
   assign line  = data_q[idx];
endmodule

// File: rtl/cache_controller.sv
// 2-way set-associative read cache, write-through / no write-allocate.
// Two cache_way instances plus the per-set LRU bits and the request FSM.
module cache_controller
   import cache_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   cache_controller_if.slave  bus,
   output cache_state_t       state
);
   addr_fields_t      f;
   cache_state_t      next_state;
   logic              hit0, hit1, valid0, valid1;
   logic              hit, hit_way, victim;
   logic [LINE_W-1:0] line0, line1, hit_line, fill_line;
   logic [31:0]       hit_word, word0_q;
   logic [SETS-1:0]   lru;
   logic              fill_we, word_we, lru_we, lru_val;

   assign f         = split_addr(bus.address);
   assign hit       = hit0 | hit1;
   assign hit_way   = hit1 & ~hit0;
   assign hit_line  = hit0 ? line0 : line1;
   assign hit_word  = f.word_sel ? hit_line[63:32] : hit_line[31:0];
   assign fill_line = {bus.sram_rdata, word0_q};
   // Invalid ways are filled first (way0 before way1), otherwise the LRU way.
   assign victim    = !valid0 ? 1'b0 : (!valid1 ? 1'b1 : lru[f.idx]);

   cache_way u_way0 (
      .clk(clk), .rst(rst), .idx(f.idx), .tag(f.tag),
      .valid(valid0), .hit(hit0), .line(line0),
      .line_we(fill_we && !victim), .line_wdata(fill_line),
      .word_we(word_we && hit0), .word_sel(f.word_sel), .word_wdata(bus.write_data)
   );

   cache_way u_way1 (
      .clk(clk), .rst(rst), .idx(f.idx), .tag(f.tag),
      .valid(valid1), .hit(hit1), .line(line1),
      .line_we(fill_we && victim), .line_wdata(fill_line),
      .word_we(word_we && hit1), .word_sel(f.word_sel), .word_wdata(bus.write_data)
   );

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (bus.rd_en)      next_state = hit ? IDLE : FILL0;
                  else if (bus.wr_en) next_state = WRITE;
         FILL0:   if (bus.sram_ready) next_state = FILL1;
         FILL1:   if (bus.sram_ready) next_state = IDLE;
         WRITE:   if (bus.sram_ready) next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // A request dropped mid-transaction lets SRAM finish but installs nothing and never acks.
   always_comb begin
      bus.ready        = 1'b0;
      bus.read_data    = '0;
      bus.sram_rd_en   = 1'b0;
      bus.sram_wr_en   = 1'b0;
      bus.sram_address = '0;
      bus.sram_wdata   = bus.write_data;
      fill_we          = 1'b0;
      word_we          = 1'b0;
      lru_we           = 1'b0;
      lru_val          = 1'b0;
      if (!rst) begin
         case (state)
            IDLE: if (bus.rd_en && hit) begin
               bus.ready     = 1'b1;
               bus.read_data = hit_word;
               lru_we        = 1'b1;
               lru_val       = !hit_way;
            end
            FILL0: begin
               bus.sram_rd_en   = 1'b1;
               bus.sram_address = {bus.address[31:3], 3'b000};
            end
            FILL1: begin
               bus.sram_rd_en   = 1'b1;
               bus.sram_address = {bus.address[31:3], 3'b100};
               if (bus.sram_ready && bus.rd_en) begin
                  bus.ready     = 1'b1;
                  bus.read_data = f.word_sel ? bus.sram_rdata : word0_q;
                  fill_we       = 1'b1;
                  lru_we        = 1'b1;
                  lru_val       = !victim;
               end
            end
            WRITE: begin
               bus.sram_wr_en   = 1'b1;
               bus.sram_address = bus.address;
               if (bus.sram_ready && bus.wr_en) begin
                  bus.ready = 1'b1;
                  word_we   = hit;
                  lru_we    = hit;
                  lru_val   = !hit_way;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) lru <= '0;
      else if (lru_we) lru[f.idx] <= lru_val;
   end

   always_ff @(posedge clk) begin
      if (state == FILL0 && bus.sram_ready) word0_q <= bus.sram_rdata;
   end
endmodule

// File: tb/tb_cache_controller.sv
// Directed bench for cache_controller with a small SRAM model whose
// transaction addresses are checked against an expected queue.
module tb_cache_controller;
   import cache_pkg::*;

   logic         clk = 1'b0;
   logic         rst;
   cache_state_t state;
   cache_controller_if bus();

   cache_controller dut (.clk(clk), .rst(rst), .bus(bus.slave), .state(state));

   always #5 clk = ~clk;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] exp_q[$];
   logic [31:0] mem [logic [31:0]];
   int          rd_txn = 0, wr_txn = 0, rd_cycles = 0, wr_cycles = 0, both_cycles = 0;
   int          sram_cnt = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] mem_rd(input logic [31:0] a);
      if (mem.exists(a)) return mem[a];
      return {16'hD000, a[15:0]};
   endfunction

   // SRAM model: responds on the second cycle of a held request with a 1-cycle sram_ready.
   initial begin
      logic [31:0] e;
      bus.sram_ready = 1'b0;
      bus.sram_rdata = '0;
      forever begin
         @(negedge clk);
         if (bus.sram_rd_en) rd_cycles++;
         if (bus.sram_wr_en) wr_cycles++;
         if (bus.sram_rd_en && bus.sram_wr_en) both_cycles++;
         if (bus.sram_ready) begin
            bus.sram_ready = 1'b0;
            sram_cnt = 0;
         end else if (rst || !(bus.sram_rd_en || bus.sram_wr_en)) begin
            sram_cnt = 0;
         end else begin
            sram_cnt++;
            if (sram_cnt == 2) begin
               e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
               check("sram_txn_addr", bus.sram_address, e);
               if (bus.sram_rd_en) begin
                  rd_txn++;
                  bus.sram_rdata = mem_rd(bus.sram_address);
               end else begin
                  wr_txn++;
                  mem[bus.sram_address] = bus.sram_wdata;
               end
               bus.sram_ready = 1'b1;
            end
         end
      end
   end

   // Drives one request, returns the data and the number of cycles until ready.
   task automatic do_req(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata, output logic [31:0] data, output int lat);
      @(negedge clk);
      bus.rd_en = rd;
      bus.wr_en = wr;
      bus.address = addr;
      bus.write_data = wdata;
      lat = -1;
      data = 'x;
      for (int c = 0; c < 200; c++) begin
         #1;
         if (bus.ready) begin
            lat = c;
            data = bus.read_data;
            break;
         end
         @(negedge clk);
      end
      checks++;
      assert (lat >= 0) else begin
         errors++;
         $error("FAIL req_timeout observed=no_ready expected=ready addr=0x%08h", addr);
      end
      @(negedge clk);
      bus.rd_en = 1'b0;
      bus.wr_en = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] d;
      int lat, r0, c0, w0, wc0;
      bus.rd_en = 1'b0;
      bus.wr_en = 1'b0;
      bus.address = '0;
      bus.write_data = '0;
      rst = 1'b1;
      mem[32'h400] = 32'h0000_000A;
      mem[32'h404] = 32'h0000_000B;
      repeat (2) @(negedge clk);
      #1;
      check("rst_state", 32'(state), 32'(IDLE));
      check("rst_ready", 32'(bus.ready), 32'd0);
      check("rst_sram_rd_en", 32'(bus.sram_rd_en), 32'd0);
      check("rst_sram_wr_en", 32'(bus.sram_wr_en), 32'd0);
      check("rst_sram_address", bus.sram_address, 32'd0);
      check("rst_read_data", bus.read_data, 32'd0);
      rst = 1'b0;

      // Cold read: two-word fill at 0x400/0x404.
      r0 = rd_txn;
      exp_q.push_back(32'h400); exp_q.push_back(32'h404);
      do_req(1'b1, 1'b0, 32'h400, 32'h0, d, lat);
      check("cold_data", d, 32'h0000_000A);
      check("cold_rd_txns", 32'(rd_txn - r0), 32'd2);
      check("cold_missed", 32'(lat > 0), 32'd1);

      c0 = rd_cycles;
      do_req(1'b1, 1'b0, 32'h404, 32'h0, d, lat);
      check("rehit_data", d, 32'h0000_000B);
      check("rehit_latency", 32'(lat), 32'd0);
      check("rehit_rd_cycles", 32'(rd_cycles - c0), 32'd0);

      // Same index, different tags: 0x600 fills way1, 0x800 evicts 0x400.
      exp_q.push_back(32'h600); exp_q.push_back(32'h604);
      do_req(1'b1, 1'b0, 32'h600, 32'h0, d, lat);
      check("fill600_data", d, 32'hD000_0600);
      check("fill600_missed", 32'(lat > 0), 32'd1);
      exp_q.push_back(32'h800); exp_q.push_back(32'h804);
      do_req(1'b1, 1'b0, 32'h800, 32'h0, d, lat);
      check("fill800_data", d, 32'hD000_0800);
      do_req(1'b1, 1'b0, 32'h600, 32'h0, d, lat);
      check("hit600_latency", 32'(lat), 32'd0);
      check("hit600_data", d, 32'hD000_0600);
      exp_q.push_back(32'h400); exp_q.push_back(32'h404);
      do_req(1'b1, 1'b0, 32'h400, 32'h0, d, lat);
      check("evicted400_missed", 32'(lat > 0), 32'd1);
      check("evicted400_data", d, 32'h0000_000A);

      // Store hit updates the cached word; store miss does not allocate.
      w0 = wr_txn; r0 = rd_txn;
      exp_q.push_back(32'h404);
      do_req(1'b0, 1'b1, 32'h404, 32'h55, d, lat);
      check("store_wr_txns", 32'(wr_txn - w0), 32'd1);
      check("store_rd_txns", 32'(rd_txn - r0), 32'd0);
      do_req(1'b1, 1'b0, 32'h404, 32'h0, d, lat);
      check("store_hit_latency", 32'(lat), 32'd0);
      check("store_hit_data", d, 32'h0000_0055);
      exp_q.push_back(32'hA08);
      do_req(1'b0, 1'b1, 32'hA08, 32'h77, d, lat);
      exp_q.push_back(32'hA08); exp_q.push_back(32'hA0C);
      do_req(1'b1, 1'b0, 32'hA08, 32'h0, d, lat);
      check("nowa_missed", 32'(lat > 0), 32'd1);
      check("nowa_data", d, 32'h0000_0077);

      // Reset during FILL1 aborts the fill.
      exp_q.push_back(32'hC00);
      @(negedge clk);
      bus.rd_en = 1'b1;
      bus.address = 32'hC00;
      for (int c = 0; c < 50; c++) begin
         #1;
         if (state == FILL1) break;
         @(negedge clk);
      end
      check("reached_fill1", 32'(state), 32'(FILL1));
      rst = 1'b1;
      @(negedge clk);
      #1;
      check("abort_state", 32'(state), 32'(IDLE));
      check("abort_sram_rd_en", 32'(bus.sram_rd_en), 32'd0);
      check("abort_sram_wr_en", 32'(bus.sram_wr_en), 32'd0);
      check("abort_ready", 32'(bus.ready), 32'd0);
      bus.rd_en = 1'b0;
      rst = 1'b0;
      exp_q.push_back(32'hC00); exp_q.push_back(32'hC04);
      do_req(1'b1, 1'b0, 32'hC00, 32'h0, d, lat);
      check("after_abort_missed", 32'(lat > 0), 32'd1);
      check("after_abort_data", d, 32'hD000_0C00);

      // Read has priority over a simultaneous write.
      wc0 = wr_cycles;
      exp_q.push_back(32'hE00); exp_q.push_back(32'hE04);
      do_req(1'b1, 1'b1, 32'hE00, 32'h99, d, lat);
      check("both_data", d, 32'hD000_0E00);
      check("both_wr_cycles", 32'(wr_cycles - wc0), 32'd0);

      check("never_both_enables", 32'(both_cycles), 32'd0);
      check("exp_q_drained", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
